// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs, forwarding sources and ALU-side outputs.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned REG_W  = 5
);
    logic              valid_in;
    logic              ready_out;
    logic              stall_in;
    logic              flush;
    logic [REG_W-1:0]  rs1_addr_in;
    logic [REG_W-1:0]  rs2_addr_in;
    logic              use_rs1;
    logic              use_rs2;
    logic [DATA_W-1:0] rs1_data_in;
    logic [DATA_W-1:0] rs2_data_in;
    logic [DATA_W-1:0] imm_in;
    logic [DATA_W-1:0] pc_in;
    logic              b_sel_in;
    logic              a_sel_pc_in;
    logic [CTRL_W-1:0] alu_ctrl_in;
    logic [REG_W-1:0]  rd_addr_in;
    logic              reg_write_in;
    logic              mem_read_in;
    logic              mem_write_in;
    logic [REG_W-1:0]  exmem_rd;
    logic              exmem_we;
    logic [DATA_W-1:0] exmem_result;
    logic [REG_W-1:0]  memwb_rd;
    logic              memwb_we;
    logic [DATA_W-1:0] memwb_result;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd_addr_out;
    logic              reg_write_out;
    logic              mem_read_out;
    logic              mem_write_out;
    logic              valid_out;
    logic              hazard_stall;

    modport master (
        output valid_in, stall_in, flush, rs1_addr_in, rs2_addr_in, use_rs1, use_rs2,
               rs1_data_in, rs2_data_in, imm_in, pc_in, b_sel_in, a_sel_pc_in,
               alu_ctrl_in, rd_addr_in, reg_write_in, mem_read_in, mem_write_in,
               exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result,
        input  ready_out, alu_a, alu_b, alu_ctrl, store_data, rd_addr_out,
               reg_write_out, mem_read_out, mem_write_out, valid_out, hazard_stall
    );

    modport slave (
        input  valid_in, stall_in, flush, rs1_addr_in, rs2_addr_in, use_rs1, use_rs2,
               rs1_data_in, rs2_data_in, imm_in, pc_in, b_sel_in, a_sel_pc_in,
               alu_ctrl_in, rd_addr_in, reg_write_in, mem_read_in, mem_write_in,
               exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result,
        output ready_out, alu_a, alu_b, alu_ctrl, store_data, rd_addr_out,
               reg_write_out, mem_read_out, mem_write_out, valid_out, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand capture, EX/MEM and MEM/WB
// forwarding, load-use bubble insertion, shift-amount masking, stall and flush.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned REG_W  = 5
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] ALU_SLL = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] ALU_SRL = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] ALU_SRA = CTRL_W'(4'b1000);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] alu_ctrl;
        logic              a_sel_pc;
        logic              b_sel;
        logic [REG_W-1:0]  rs1_addr;
        logic [REG_W-1:0]  rs2_addr;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
    } stage_t;

    stage_t            stage_q, stage_d;
    logic              hazard_stall;
    logic [DATA_W-1:0] fwd_rs1, fwd_rs2, b_raw;

    // EX/MEM beats MEM/WB; x0 is never a forwarding target.
    function automatic logic [DATA_W-1:0] forward(input logic [REG_W-1:0] rs,
                                                  input logic [DATA_W-1:0] rf_val);
        if (bus.exmem_we && bus.exmem_rd != '0 && bus.exmem_rd == rs)
            return bus.exmem_result;
        else if (bus.memwb_we && bus.memwb_rd != '0 && bus.memwb_rd == rs)
            return bus.memwb_result;
        else
            return rf_val;
    endfunction

    // Load-use detection: held load's rd is read by the incoming instruction.
    always_comb begin
        hazard_stall = 1'b0;
        if (bus.valid_in && stage_q.valid && stage_q.mem_read && stage_q.rd != '0)
            hazard_stall = (bus.use_rs1 && bus.rs1_addr_in == stage_q.rd) ||
                           (bus.use_rs2 && bus.rs2_addr_in == stage_q.rd);
    end

    // Next-state selection: flush > hold > load-use bubble > capture > bubble.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush || (!bus.stall_in && (hazard_stall || !bus.valid_in))) begin
            stage_d.valid     = 1'b0;
            stage_d.reg_write = 1'b0;
            stage_d.mem_read  = 1'b0;
            stage_d.mem_write = 1'b0;
            stage_d.alu_ctrl  = ALU_ADD;
        end else if (!bus.stall_in) begin
            stage_d.valid     = 1'b1;
            stage_d.reg_write = bus.reg_write_in;
            stage_d.mem_read  = bus.mem_read_in;
            stage_d.mem_write = bus.mem_write_in;
            stage_d.rd        = bus.rd_addr_in;
            stage_d.alu_ctrl  = bus.alu_ctrl_in;
            stage_d.a_sel_pc  = bus.a_sel_pc_in;
            stage_d.b_sel     = bus.b_sel_in;
            stage_d.rs1_addr  = bus.rs1_addr_in;
            stage_d.rs2_addr  = bus.rs2_addr_in;
            stage_d.rs1_data  = bus.rs1_data_in;
            stage_d.rs2_data  = bus.rs2_data_in;
            stage_d.imm       = bus.imm_in;
            stage_d.pc        = bus.pc_in;
        end
    end

    // Stage register with synchronous reset to an ADD bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q          <= '0;
            stage_q.alu_ctrl <= ALU_ADD;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Operand muxing with forwarding and shift-amount masking.
    always_comb begin
        fwd_rs1 = forward(stage_q.rs1_addr, stage_q.rs1_data);
        fwd_rs2 = forward(stage_q.rs2_addr, stage_q.rs2_data);
        b_raw   = stage_q.b_sel ? stage_q.imm : fwd_rs2;
        bus.alu_a = stage_q.a_sel_pc ? stage_q.pc : fwd_rs1;
        bus.alu_b = b_raw;
        if (stage_q.alu_ctrl inside {ALU_SLL, ALU_SRL, ALU_SRA})
            bus.alu_b = {{(DATA_W-5){1'b0}}, b_raw[4:0]};
    end

    assign bus.store_data    = fwd_rs2;
    assign bus.alu_ctrl      = stage_q.alu_ctrl;
    assign bus.rd_addr_out   = stage_q.rd;
    assign bus.reg_write_out = stage_q.reg_write;
    assign bus.mem_read_out  = stage_q.mem_read;
    assign bus.mem_write_out = stage_q.mem_write;
    assign bus.valid_out     = stage_q.valid;
    assign bus.hazard_stall  = hazard_stall;
    assign bus.ready_out     = !bus.stall_in && !hazard_stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instruction sequence, per-cycle model comparison
// and literal expectations for the key scenarios.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    // Model of the instruction currently sitting in the stage.
    typedef struct packed {
        logic        v, rw, mr, mw, use_pc, use_imm;
        logic [4:0]  rd, ra1, ra2;
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc;
    } held_t;
    held_t m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (bus.exmem_we && bus.exmem_rd != 0 && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_we && bus.memwb_rd != 0 && bus.memwb_rd == r) return bus.memwb_result;
        return rf;
    endfunction

    function automatic logic model_hazard();
        return bus.valid_in && m.v && m.mr && m.rd != 0 &&
               ((bus.use_rs1 && bus.rs1_addr_in == m.rd) ||
                (bus.use_rs2 && bus.rs2_addr_in == m.rd));
    endfunction

    // Model update on each rising edge.
    always @(posedge clk) begin
        held_t bubble;
        bubble = m;
        bubble.v = 0; bubble.rw = 0; bubble.mr = 0; bubble.mw = 0; bubble.op = 4'd2;
        if (rst) begin
            m = '0; m.op = 4'd2;
        end else if (bus.flush) m = bubble;
        else if (bus.stall_in) m = m;
        else if (model_hazard()) m = bubble;
        else if (bus.valid_in) begin
            m.v = 1; m.rw = bus.reg_write_in; m.mr = bus.mem_read_in; m.mw = bus.mem_write_in;
            m.use_pc = bus.a_sel_pc_in; m.use_imm = bus.b_sel_in;
            m.rd = bus.rd_addr_in; m.ra1 = bus.rs1_addr_in; m.ra2 = bus.rs2_addr_in;
            m.op = bus.alu_ctrl_in; m.a = bus.rs1_data_in; m.b = bus.rs2_data_in;
            m.imm = bus.imm_in; m.pc = bus.pc_in;
        end else m = bubble;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic        h;
        logic [31:0] eb;
        h = model_hazard();
        chk("m_hazard", 32'(bus.hazard_stall), 32'(h));
        chk("m_ready", 32'(bus.ready_out), 32'(!bus.stall_in && !h));
        chk("m_valid", 32'(bus.valid_out), 32'(m.v));
        chk("m_rw", 32'(bus.reg_write_out), 32'(m.rw));
        chk("m_mr", 32'(bus.mem_read_out), 32'(m.mr));
        chk("m_mw", 32'(bus.mem_write_out), 32'(m.mw));
        chk("m_ctrl", 32'(bus.alu_ctrl), 32'(m.op));
        if (m.v) begin
            eb = m.use_imm ? m.imm : fwd(m.ra2, m.b);
            if (m.op == 4'd6 || m.op == 4'd7 || m.op == 4'd8) eb = eb % 32;
            chk("m_rd", 32'(bus.rd_addr_out), 32'(m.rd));
            chk("m_alu_a", bus.alu_a, m.use_pc ? m.pc : fwd(m.ra1, m.a));
            chk("m_alu_b", bus.alu_b, eb);
            chk("m_store", bus.store_data, fwd(m.ra2, m.b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        bus.exmem_rd = 0; bus.exmem_we = 0; bus.exmem_result = 0;
        bus.memwb_rd = 0; bus.memwb_we = 0; bus.memwb_result = 0;
    endtask

    // Present one decoded instruction (valid_in set separately).
    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                         input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic bsel,
                         input logic asel, input logic [3:0] op, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw);
        bus.rs1_addr_in = r1; bus.rs2_addr_in = r2; bus.use_rs1 = u1; bus.use_rs2 = u2;
        bus.rs1_data_in = d1; bus.rs2_data_in = d2; bus.imm_in = imm; bus.pc_in = pc;
        bus.b_sel_in = bsel; bus.a_sel_pc_in = asel; bus.alu_ctrl_in = op;
        bus.rd_addr_in = rd; bus.reg_write_in = rw; bus.mem_read_in = mr;
        bus.mem_write_in = mw;
    endtask

    initial begin
        rst = 1; bus.valid_in = 0; bus.stall_in = 0; bus.flush = 0;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        clr_fwd();
        tick(); tick();
        rst = 0;
        chk("rst_ctrl", 32'(bus.alu_ctrl), 32'h2);
        chk("rst_valid", 32'(bus.valid_out), 32'h0);
        chk("rst_ready", 32'(bus.ready_out), 32'h1);

        // ADD x3,x1,x2
        issue(1, 2, 1, 1, 32'd5, 32'd7, 0, 32'h40, 0, 0, 4'd2, 3, 1, 0, 0);
        bus.valid_in = 1; tick(); bus.valid_in = 0;
        chk("add_a", bus.alu_a, 32'd5);
        chk("add_b", bus.alu_b, 32'd7);
        chk("add_ctrl", 32'(bus.alu_ctrl), 32'h2);
        chk("add_valid", 32'(bus.valid_out), 32'h1);

        // Forwarding priority and x0 exclusion
        issue(1, 2, 1, 1, 32'h11, 32'h22, 0, 0, 0, 0, 4'd2, 6, 1, 0, 0);
        bus.valid_in = 1; tick(); bus.valid_in = 0;
        bus.exmem_rd = 1; bus.exmem_we = 1; bus.exmem_result = 32'hAA;
        bus.memwb_rd = 1; bus.memwb_we = 1; bus.memwb_result = 32'hBB;
        #1 chk("fwd_exmem_first", bus.alu_a, 32'hAA);
        bus.exmem_we = 0;
        #1 chk("fwd_memwb", bus.alu_a, 32'hBB);
        bus.exmem_we = 1; bus.exmem_rd = 0; bus.memwb_rd = 0;
        #1 chk("fwd_rd0", bus.alu_a, 32'h11);
        clr_fwd();

        // Store with forwarded rs2 and immediate B
        issue(1, 2, 1, 1, 32'h100, 32'h22, 32'd8, 0, 1, 0, 4'd2, 0, 0, 0, 1);
        bus.valid_in = 1; tick(); bus.valid_in = 0;
        bus.exmem_rd = 2; bus.exmem_we = 1; bus.exmem_result = 32'hCC;
        #1 chk("st_b", bus.alu_b, 32'd8);
        chk("st_data", bus.store_data, 32'hCC);
        chk("st_a", bus.alu_a, 32'h100);
        chk("st_mw", 32'(bus.mem_write_out), 32'h1);
        clr_fwd();

        // AUIPC: A from pc
        issue(7, 0, 0, 0, 32'h77, 0, 32'h1000, 32'h100, 1, 1, 4'd2, 8, 1, 0, 0);
        bus.valid_in = 1; tick();
        chk("auipc_a", bus.alu_a, 32'h100);
        chk("auipc_b", bus.alu_b, 32'h1000);

        // Load-use: LW x4 then ADD x5,x4,x2
        issue(1, 0, 1, 0, 32'h200, 0, 32'd4, 0, 1, 0, 4'd2, 4, 1, 1, 0);
        tick();
        issue(4, 2, 1, 1, 32'h0, 32'd7, 0, 0, 0, 0, 4'd2, 5, 1, 0, 0);
        #1 chk("lu_hazard", 32'(bus.hazard_stall), 32'h1);
        chk("lu_ready", 32'(bus.ready_out), 32'h0);
        tick();
        chk("lu_bubble", 32'(bus.valid_out), 32'h0);
        chk("lu_bubble_rw", 32'(bus.reg_write_out), 32'h0);
        chk("lu_ready_again", 32'(bus.ready_out), 32'h1);
        tick();
        bus.memwb_rd = 4; bus.memwb_we = 1; bus.memwb_result = 32'h44;
        #1 chk("lu_cap_valid", 32'(bus.valid_out), 32'h1);
        chk("lu_cap_rd", 32'(bus.rd_addr_out), 32'd5);
        chk("lu_cap_a", bus.alu_a, 32'h44);
        clr_fwd();

        // No hazard when the register is not read, or the load targets x0
        issue(1, 0, 1, 0, 32'h200, 0, 32'd4, 0, 1, 0, 4'd2, 4, 1, 1, 0);
        tick();
        issue(4, 4, 0, 0, 0, 0, 32'h12345, 0, 1, 0, 4'd2, 9, 1, 0, 0);
        #1 chk("nohaz_unused", 32'(bus.hazard_stall), 32'h0);
        tick();
        issue(1, 0, 1, 0, 32'h200, 0, 32'd4, 0, 1, 0, 4'd2, 0, 1, 1, 0);
        tick();
        issue(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'd2, 9, 1, 0, 0);
        #1 chk("nohaz_x0", 32'(bus.hazard_stall), 32'h0);
        tick();

        // Shift masking
        issue(1, 2, 1, 1, 32'd1, 32'hFFFF_FF23, 0, 0, 0, 0, 4'd6, 9, 1, 0, 0);
        tick();
        chk("sll_b", bus.alu_b, 32'd3);
        issue(1, 0, 1, 0, 32'd1, 0, 32'h45, 0, 1, 0, 4'd8, 9, 1, 0, 0);
        tick();
        chk("sra_b", bus.alu_b, 32'd5);
        issue(1, 2, 1, 1, 32'd1, 32'hFFFF_FF23, 0, 0, 0, 0, 4'd0, 10, 1, 0, 0);
        tick();
        chk("and_b", bus.alu_b, 32'hFFFF_FF23);

        // Stall holds contents
        bus.stall_in = 1;
        issue(1, 2, 1, 1, 32'd9, 32'd9, 0, 0, 0, 0, 4'd2, 11, 1, 0, 0);
        #1 chk("stall_ready", 32'(bus.ready_out), 32'h0);
        tick();
        chk("hold_rd", 32'(bus.rd_addr_out), 32'd10);
        chk("hold_valid", 32'(bus.valid_out), 32'h1);

        // Stall with a pending load-use: hold wins, no bubble
        bus.stall_in = 0;
        issue(1, 0, 1, 0, 32'h200, 0, 32'd4, 0, 1, 0, 4'd2, 4, 1, 1, 0);
        tick();
        bus.stall_in = 1;
        issue(4, 2, 1, 1, 0, 32'd7, 0, 0, 0, 0, 4'd2, 5, 1, 0, 0);
        #1 chk("sh_hazard", 32'(bus.hazard_stall), 32'h1);
        tick();
        chk("sh_valid", 32'(bus.valid_out), 32'h1);
        chk("sh_mr", 32'(bus.mem_read_out), 32'h1);
        chk("sh_rd", 32'(bus.rd_addr_out), 32'd4);

        // Flush during stall clears the stage
        bus.flush = 1;
        tick();
        chk("fl_valid", 32'(bus.valid_out), 32'h0);
        chk("fl_rw", 32'(bus.reg_write_out), 32'h0);
        bus.flush = 0; bus.stall_in = 0; bus.valid_in = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
